// File: rtl/garage_pkg.sv
// Shared definitions for the garage gate controller.
//   gate_state_e      : controller FSM states (IDLE=0, ENTRY_OPEN=1, EXIT_OPEN=2, CLOSE=3)
//   DEF_CAPACITY      : default garage capacity
//   DEF_GATE_TIMEOUT  : default gate open window in cycles
package garage_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSE      = 2'd3
  } gate_state_e;

  localparam int DEF_CAPACITY     = 50;
  localparam int DEF_GATE_TIMEOUT = 64;

endpackage

// File: rtl/garage_gate_ctrl_if.sv
// Lane I/O and status bundle of the garage gate controller.
//   entry_btn/exit_btn     : raw, bouncy driver request buttons
//   entry_pass/exit_pass   : synchronous pass sensors
//   entry_gate/exit_gate   : gate open commands
//   count/full/empty/almost_full : occupancy status
//   reject/timeout         : one-cycle event pulses
// master = lane/display side, slave = controller.
interface garage_gate_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             entry_btn;
  logic             exit_btn;
  logic             entry_pass;
  logic             exit_pass;
  logic             entry_gate;
  logic             exit_gate;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             reject;
  logic             timeout;

  modport master (
    output entry_btn, exit_btn, entry_pass, exit_pass,
    input  entry_gate, exit_gate, count, full, empty, almost_full, reject, timeout
  );

  modport slave (
    input  entry_btn, exit_btn, entry_pass, exit_pass,
    output entry_gate, exit_gate, count, full, empty, almost_full, reject, timeout
  );
endinterface

// File: rtl/garage_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   raw   : asynchronous bouncy button level
//   evt   : one-cycle pulse, DEBOUNCE+2 cycles after a stable press
module garage_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic evt
);

  localparam int            CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The accepted level only moves after DEBOUNCE consecutive samples that
  // disagree with it; any agreeing sample restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    evt_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = sync2_q;
        evt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/garage_gate_ctrl.sv
// Garage occupancy and gate controller with separate entry and exit lanes.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : lane I/O and status (garage_gate_ctrl_if.slave)
// A debounced button request opens its lane's gate; occupancy changes only
// on that lane's pass-sensor rising edge. Exit requests win over entry.
module garage_gate_ctrl
  import garage_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = $clog2(CAPACITY + 1),
  parameter int DEBOUNCE     = 4,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int ALMOST_FULL  = CAPACITY - 2
) (
  input  logic               clk,
  input  logic               reset,
  garage_gate_ctrl_if.slave  bus
);

  localparam int               TW     = $clog2(GATE_TIMEOUT);
  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [TW-1:0]    TLAST  = TW'(GATE_TIMEOUT - 1);

  gate_state_e      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_entry_q, pend_entry_d;
  logic             pend_exit_q, pend_exit_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic             entry_gate_q, exit_gate_q;
  logic             full_q, empty_q, afull_q;
  logic             entry_pass_q, exit_pass_q;
  logic             entry_evt, exit_evt;
  logic             entry_pass_evt, exit_pass_evt;
  logic             entry_req, exit_req;

  garage_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry_db (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.entry_btn),
    .evt   (entry_evt)
  );

  garage_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_db (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.exit_btn),
    .evt   (exit_evt)
  );

  assign entry_pass_evt = bus.entry_pass & ~entry_pass_q;
  assign exit_pass_evt  = bus.exit_pass  & ~exit_pass_q;
  assign entry_req      = entry_evt | pend_entry_q;
  assign exit_req       = exit_evt  | pend_exit_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    count_d      = count_q;
    pend_entry_d = pend_entry_q;
    pend_exit_d  = pend_exit_q;
    reject_d     = 1'b0;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exit_req) begin
          // A concurrent entry press is parked so it is served next.
          pend_exit_d  = 1'b0;
          pend_entry_d = pend_entry_q | entry_evt;
          if (count_q != '0) state_d = EXIT_OPEN;
        end else if (entry_req) begin
          pend_entry_d = 1'b0;
          if (full_q) reject_d = 1'b1;
          else        state_d  = ENTRY_OPEN;
        end
      end
      ENTRY_OPEN: begin
        timer_d = timer_q + TW'(1);
        if (exit_evt) pend_exit_d = 1'b1;
        if (entry_pass_evt) begin
          if (count_q < CAP_C) count_d = count_q + CNT_W'(1);
          state_d = CLOSE;
          timer_d = '0;
        end else if (timer_q == TLAST) begin
          timeout_d = 1'b1;
          state_d   = CLOSE;
          timer_d   = '0;
        end
      end
      EXIT_OPEN: begin
        timer_d = timer_q + TW'(1);
        if (entry_evt) pend_entry_d = 1'b1;
        if (exit_pass_evt) begin
          if (count_q != '0) count_d = count_q - CNT_W'(1);
          state_d = CLOSE;
          timer_d = '0;
        end else if (timer_q == TLAST) begin
          timeout_d = 1'b1;
          state_d   = CLOSE;
          timer_d   = '0;
        end
      end
      CLOSE: begin
        state_d      = IDLE;
        pend_entry_d = pend_entry_q | entry_evt;
        pend_exit_d  = pend_exit_q  | exit_evt;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gates and status flags are registered from next-state values so they line
  // up with the state/count they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      count_q      <= '0;
      pend_entry_q <= 1'b0;
      pend_exit_q  <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      entry_gate_q <= 1'b0;
      exit_gate_q  <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= (ALMOST_FULL <= 0);
      entry_pass_q <= 1'b0;
      exit_pass_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      pend_entry_q <= pend_entry_d;
      pend_exit_q  <= pend_exit_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
      entry_gate_q <= (state_d == ENTRY_OPEN);
      exit_gate_q  <= (state_d == EXIT_OPEN);
      full_q       <= (count_d == CAP_C);
      empty_q      <= (count_d == '0);
      afull_q      <= (int'(count_d) >= ALMOST_FULL);
      entry_pass_q <= bus.entry_pass;
      exit_pass_q  <= bus.exit_pass;
    end
  end

  assign bus.entry_gate  = entry_gate_q;
  assign bus.exit_gate   = exit_gate_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = afull_q;
  assign bus.reject      = reject_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_garage_gate_ctrl.sv
// Randomised self-checking bench for garage_gate_ctrl (CAPACITY=3, DEBOUNCE=2,
// GATE_TIMEOUT=8). The reference keeps only an occupancy integer and derives
// expected latencies, gate windows and pulses from the lane rules.
module tb_garage_gate_ctrl;

  localparam int CAP = 3;
  localparam int DEB = 2;
  localparam int TMO = 8;
  localparam int CW  = $clog2(CAP + 1);
  localparam int AF  = CAP - 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  garage_gate_ctrl_if #(.CNT_W(CW)) bus ();

  garage_gate_ctrl #(
    .CAPACITY     (CAP),
    .CNT_W        (CW),
    .DEBOUNCE     (DEB),
    .GATE_TIMEOUT (TMO),
    .ALMOST_FULL  (AF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int mdl  = 0;
  int ent_cyc = 0, ext_cyc = 0, rej_cnt = 0, to_cnt = 0, both_cnt = 0;

  // Cycle monitor, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      ent_cyc  += int'(bus.entry_gate);
      ext_cyc  += int'(bus.exit_gate);
      rej_cnt  += int'(bus.reject);
      to_cnt   += int'(bus.timeout);
      both_cnt += int'(bus.entry_gate & bus.exit_gate);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flags(input string tag);
    check({tag, "/count"}, 32'(bus.count), mdl);
    check({tag, "/full"},  32'(bus.full),  32'(mdl == CAP));
    check({tag, "/empty"}, 32'(bus.empty), 32'(mdl == 0));
    check({tag, "/afull"}, 32'(bus.almost_full), 32'(mdl >= AF));
  endtask

  // Bounce (1-cycle glitches) then hold; returns cycles from stable press
  // until any gate is seen open (capped at 40), then releases.
  task automatic press(input bit ent, input bit ext, input int bounces, output int lat);
    for (int b = 0; b < bounces; b++) begin
      bus.entry_btn = ent; bus.exit_btn = ext; tick(1);
      bus.entry_btn = 1'b0; bus.exit_btn = 1'b0; tick(1);
    end
    bus.entry_btn = ent; bus.exit_btn = ext;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!(bus.entry_gate | bus.exit_gate) && lat < 40);
    bus.entry_btn = 1'b0; bus.exit_btn = 1'b0;
  endtask

  // Called on the cycle the gate is first seen open (timer 0): fires the pass
  // sensor d cycles later and checks the count/flags update on that edge.
  task automatic pass_lane(input bit ent, input int d);
    tick(d);
    if (ent) bus.entry_pass = 1'b1; else bus.exit_pass = 1'b1;
    tick(1);
    check("upd/count", 32'(bus.count), mdl);
    check("upd/empty", 32'(bus.empty), 32'(mdl == 0));
    check("upd/full",  32'(bus.full),  32'(mdl == CAP));
    check("upd/gates", 32'(bus.entry_gate | bus.exit_gate), 0);
    bus.entry_pass = 1'b0; bus.exit_pass = 1'b0;
  endtask

  task automatic wait_closed();
    int g;
    g = 0;
    while ((bus.entry_gate | bus.exit_gate) && g < 30) begin
      tick(1);
      g++;
    end
    check("close_bound", 32'(g < 30), 1);
    tick(6);
  endtask

  task automatic do_entry(input bit with_pass, input int bounces);
    int e0, x0, r0, t0, lat, d;
    e0 = ent_cyc; x0 = ext_cyc; r0 = rej_cnt; t0 = to_cnt;
    press(1'b1, 1'b0, bounces, lat);
    if (mdl == CAP) begin
      tick(4);
      check("rej/pulse", rej_cnt - r0, 1);
      check("rej/gate", ent_cyc - e0, 0);
      flags("rej");
      return;
    end
    check("ent/lat",  lat, DEB + 3);
    check("ent/gate", 32'(bus.entry_gate), 1);
    if (with_pass) begin
      d = $urandom_range(0, TMO - 1);
      mdl++;
      pass_lane(1'b1, d);
      wait_closed();
      check("ent/win", ent_cyc - e0, d + 1);
      check("ent/to",  to_cnt - t0, 0);
    end else begin
      wait_closed();
      check("ent/win", ent_cyc - e0, TMO);
      check("ent/to",  to_cnt - t0, 1);
    end
    check("ent/xgate", ext_cyc - x0, 0);
    check("ent/rej",   rej_cnt - r0, 0);
    flags("ent");
  endtask

  task automatic do_exit(input bit with_pass);
    int e0, x0, r0, t0, lat, d;
    e0 = ent_cyc; x0 = ext_cyc; r0 = rej_cnt; t0 = to_cnt;
    press(1'b0, 1'b1, $urandom_range(0, 3), lat);
    if (mdl == 0) begin
      tick(4);
      check("drop/gates", (ent_cyc - e0) + (ext_cyc - x0), 0);
      check("drop/rej", rej_cnt - r0, 0);
      flags("drop");
      return;
    end
    check("ext/lat",  lat, DEB + 3);
    check("ext/gate", 32'(bus.exit_gate), 1);
    if (with_pass) begin
      d = $urandom_range(0, TMO - 1);
      mdl--;
      pass_lane(1'b0, d);
      wait_closed();
      check("ext/win", ext_cyc - x0, d + 1);
      check("ext/to",  to_cnt - t0, 0);
    end else begin
      wait_closed();
      check("ext/win", ext_cyc - x0, TMO);
      check("ext/to",  to_cnt - t0, 1);
    end
    check("ext/egate", ent_cyc - e0, 0);
    flags("ext");
  endtask

  // Both buttons settle together: exit served, CLOSE + IDLE, then entry.
  task automatic do_both();
    int e0, x0, lat, d, d2, g;
    e0 = ent_cyc; x0 = ext_cyc;
    press(1'b1, 1'b1, 0, lat);
    check("both/lat",   lat, DEB + 3);
    check("both/xgate", 32'(bus.exit_gate), 1);
    check("both/egate", 32'(bus.entry_gate), 0);
    d = $urandom_range(0, TMO - 1);
    mdl--;
    pass_lane(1'b0, d);
    g = 0;
    while (!bus.entry_gate && g < 20) begin
      g++;
      tick(1);
    end
    check("both/gap", g, 2);
    d2 = $urandom_range(0, TMO - 1);
    mdl++;
    pass_lane(1'b1, d2);
    wait_closed();
    check("both/xwin", ext_cyc - x0, d + 1);
    check("both/ewin", ent_cyc - e0, d2 + 1);
    flags("both");
  endtask

  initial begin
    int lat, e0, x0, r0, sel;
    bus.entry_btn = 1'b0; bus.exit_btn = 1'b0;
    bus.entry_pass = 1'b0; bus.exit_pass = 1'b0;
    reset = 1'b0;
    tick(3);
    flags("rst");
    check("rst/egate",   32'(bus.entry_gate), 0);
    check("rst/xgate",   32'(bus.exit_gate), 0);
    check("rst/reject",  32'(bus.reject), 0);
    check("rst/timeout", 32'(bus.timeout), 0);
    reset = 1'b1;
    tick(3);

    do_entry(1'b1, 3);          // bouncy press, one window, 0 -> 1
    do_entry(1'b1, 2);
    do_entry(1'b1, 1);          // now full
    do_entry(1'b1, 2);          // refused
    do_exit(1'b1);              // 3 -> 2
    do_entry(1'b0, 0);          // timeout
    do_both();                  // count 2: exit first, then entry
    do_exit(1'b1);
    do_exit(1'b1);
    do_exit(1'b1);              // 0
    do_exit(1'b1);              // dropped at empty

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: do_entry(1'b1, $urandom_range(0, 3));
        1: do_entry(1'b0, $urandom_range(0, 3));
        2: do_exit(1'b1);
        3: do_exit(1'b0);
        default: if (mdl >= 1) do_both(); else do_entry(1'b1, 0);
      endcase
    end

    // Reset while the entry gate is open and an exit is pending.
    while (mdl < 2) do_entry(1'b1, 0);
    press(1'b1, 1'b0, 0, lat);
    check("mid/egate", 32'(bus.entry_gate), 1);
    bus.exit_btn = 1'b1;
    tick(5);
    check("mid/still_open", 32'(bus.entry_gate), 1);
    #2;
    reset = 1'b0;
    #1;
    mdl = 0;
    check("mid/egate_off", 32'(bus.entry_gate), 0);
    check("mid/xgate_off", 32'(bus.exit_gate), 0);
    flags("mid");
    bus.exit_btn = 1'b0;
    tick(2);
    reset = 1'b1;
    e0 = ent_cyc; x0 = ext_cyc; r0 = rej_cnt;
    tick(25);
    check("post/gates", (ent_cyc - e0) + (ext_cyc - x0), 0);
    check("post/rej", rej_cnt - r0, 0);
    flags("post");

    check("overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/garage_gate_ctrl.md
Name: garage_gate_ctrl

Overview:
- Parametrised occupancy and gate controller for a garage with separate entry and exit lanes.
- Debounces the driver request buttons and opens the matching gate.
- Counts a car in or out only when that lane's pass sensor confirms the car went through.
- Provides full/empty/almost-full status, refusal pulses and a gate timeout. Sits between the lane I/O and the display/status logic.

Parameters:
- CAPACITY, 50, maximum cars; legal range 1..1023.
- CNT_W, $clog2(CAPACITY+1), width of the occupancy counter.
- DEBOUNCE, 4, number of consecutive equal samples before a button level is accepted; legal range ≥1.
- GATE_TIMEOUT, 64, cycles a gate stays open waiting for its pass sensor; legal range ≥2.
- ALMOST_FULL, CAPACITY-2, occupancy at or above which almost_full is asserted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_btn  in  1  raw entry request button, asynchronous and bouncy.
- exit_btn  in  1  raw exit request button, asynchronous and bouncy.
- entry_pass  in  1  entry lane pass sensor, synchronous level.
- exit_pass  in  1  exit lane pass sensor, synchronous level.
- entry_gate  out  1  entry gate open command.
- exit_gate  out  1  exit gate open command.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL.
- reject  out  1  one-cycle pulse when an entry request is refused because the garage is full.
- timeout  out  1  one-cycle pulse when a gate closes without a pass event.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, empty=1, full=0, almost_full=(ALMOST_FULL==0).
  - Both gates 0; reject=0, timeout=0.
  - FSM in IDLE; pending flags, timer and debouncers cleared.
  - Reset asserted mid-operation closes the gates immediately and discards any pending request.
- Button path:
  - 2-flop synchroniser, then debouncer, then rising-edge detect.
  - Produces entry_evt/exit_evt as single-cycle pulses.
  - Latency from a stable button press to evt is DEBOUNCE+2 cycles.
- Pass sensors: rising-edge detected only (entry_pass_evt, exit_pass_evt). No debounce.
- Status flags are registered from count and valid in the same cycle count updates.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSE.
- IDLE:
  - Request sources: exit_evt or pend_exit serves exit; otherwise entry_evt or pend_entry serves entry. Exit has priority.
  - Exit with count>0: go to EXIT_OPEN, clear pend_exit.
  - Exit with count==0: dropped silently, clear pend_exit.
  - Entry with full=1: reject pulses 1 cycle, stay in IDLE, clear pend_entry.
  - Entry otherwise: go to ENTRY_OPEN, clear pend_entry.
  - Simultaneous entry_evt and exit_evt: serve exit; set pend_entry.
- ENTRY_OPEN:
  - entry_gate=1; timer counts from 0.
  - entry_pass_evt: count+1 on that edge, then go to CLOSE.
  - Timer reaches GATE_TIMEOUT-1 without a pass: timeout pulse, go to CLOSE, count unchanged.
- EXIT_OPEN: symmetric to ENTRY_OPEN; exit_gate=1, count-1 on exit_pass_evt.
- CLOSE: both gates 0 for exactly 1 cycle, then IDLE.
- Opposite-lane events while a gate is open set the one-deep pend flag for that lane. Repeat events for the already-pending lane are ignored.
- Pass events outside the matching OPEN state are ignored; count never changes.
- count saturates: never above CAPACITY, never below 0, never wraps. Full is re-checked when a pending entry is served.
- At most one gate is open at any time. Gate outputs are registered, asserted the cycle after the state transition.

Decomposition:
- Package garage_pkg: FSM state encoding constants (IDLE=0, ENTRY_OPEN=1, EXIT_OPEN=2, CLOSE=3) and the default CAPACITY and GATE_TIMEOUT.
- Sub-module garage_debounce (params DEBOUNCE; ports clk, reset, raw, evt): synchroniser, stability counter and edge detect. Instantiated twice.

Test Plan:
All scenarios use CAPACITY=3, DEBOUNCE=2, GATE_TIMEOUT=8.
1. Reset, then entry_btn held 10 cycles with bounces shorter than 2 cycles, then entry_pass pulse -> exactly one entry_gate window; count 0→1; empty falls the cycle count updates.
2. Three complete entries, then a 4th entry_btn -> full=1, count=3, reject pulses once, entry_gate stays 0; almost_full=1 from count=1.
3. entry_btn with no entry_pass -> entry_gate high for 8 cycles, timeout pulses once, count unchanged.
4. count=2; entry_btn and exit_btn debounce on the same cycle -> exit served first (count 1); then CLOSE 1 cycle; then entry served (count 2); gates never both 1.
5. count=0; exit_btn -> no gate opens, count stays 0, no reject pulse.
6. reset asserted while entry_gate=1 and pend_exit=1 -> gates 0 asynchronously; count=0; after release no exit is served.
